// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between I-cache fills and
// D-cache fills/writebacks. Exactly one transaction is outstanding at a time.
// D-cache wins conflicts, but after DWIN_MAX consecutive D grants with an
// I request waiting, the I-cache is granted next so fetch always progresses.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ic_req/ic_addr              I-cache read request (level) and word address
//   ic_grant/ic_done/ic_rdata   I transaction in progress, done pulse, read data
//   dc_req/dc_wr/dc_addr/dc_wdata  D-cache request, write flag, address, data
//   dc_grant/dc_done/dc_rdata   D transaction in progress, done pulse, read data
//   mem_en/mem_wr/mem_addr/mem_wdata  memory command (held for the access)
//   mem_rdata                   memory read data, valid on the final BUSY cycle
//
// Optional build macro ARB_STATS_EN adds ic_grant_cnt, dc_grant_cnt and
// conflict_cnt (16-bit saturating statistics counters).
module mem_arbiter #(
  parameter int MEM_LAT  = 4,
  parameter int DWIN_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  output logic        ic_grant,
  output logic        ic_done,
  output logic [15:0] ic_rdata,
  input  logic        dc_req,
  input  logic        dc_wr,
  input  logic [15:0] dc_addr,
  input  logic [15:0] dc_wdata,
  output logic        dc_grant,
  output logic        dc_done,
  output logic [15:0] dc_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
`ifdef ARB_STATS_EN
  output logic [15:0] ic_grant_cnt,
  output logic [15:0] dc_grant_cnt,
  output logic [15:0] conflict_cnt,
`endif
  input  logic [15:0] mem_rdata
);

  localparam int CntW = $clog2(MEM_LAT + 1) + 1;
  localparam int WinW = $clog2(DWIN_MAX + 1) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  stateT           state;
  logic            ownerD;
  logic [CntW-1:0] cnt;
  logic [WinW-1:0] dWin;
  logic            grantNow;
  logic            pickD;

  // A grant is issued on any IDLE cycle with a pending request. D wins
  // unless the I-cache has already been passed over DWIN_MAX times in a row.
  assign grantNow = (state == IDLE) && (ic_req || dc_req);
  assign pickD    = dc_req && !(ic_req && (dWin == WinW'(DWIN_MAX)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ownerD    <= 1'b0;
      cnt       <= '0;
      dWin      <= '0;
      ic_grant  <= 1'b0;
      ic_done   <= 1'b0;
      ic_rdata  <= 16'h0;
      dc_grant  <= 1'b0;
      dc_done   <= 1'b0;
      dc_rdata  <= 16'h0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= 16'h0;
      mem_wdata <= 16'h0;
    end else begin
      ic_done <= 1'b0;
      dc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grantNow) begin
            state     <= BUSY;
            ownerD    <= pickD;
            cnt       <= CntW'(1);
            mem_en    <= 1'b1;
            ic_grant  <= !pickD;
            dc_grant  <= pickD;
            mem_wr    <= pickD && dc_wr;
            mem_addr  <= pickD ? dc_addr : ic_addr;
            mem_wdata <= pickD ? dc_wdata : 16'h0;
            // Only D grants that bypass a waiting I request extend the window.
            if (pickD && ic_req) begin
              if (dWin != WinW'(DWIN_MAX)) dWin <= dWin + WinW'(1);
            end else begin
              dWin <= '0;
            end
          end
        end
        BUSY: begin
          if (cnt == CntW'(MEM_LAT)) begin
            state    <= DONE;
            mem_en   <= 1'b0;
            mem_wr   <= 1'b0;
            ic_grant <= 1'b0;
            dc_grant <= 1'b0;
            if (ownerD) begin
              dc_done <= 1'b1;
              // Writes leave the D read-data register untouched.
              if (!mem_wr) dc_rdata <= mem_rdata;
            end else begin
              ic_done  <= 1'b1;
              ic_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_grant_cnt <= 16'h0;
      dc_grant_cnt <= 16'h0;
      conflict_cnt <= 16'h0;
    end else begin
      if (grantNow) begin
        if (pickD) begin
          if (dc_grant_cnt != 16'hFFFF) dc_grant_cnt <= dc_grant_cnt + 16'd1;
        end else begin
          if (ic_grant_cnt != 16'hFFFF) ic_grant_cnt <= ic_grant_cnt + 16'd1;
        end
      end
      if ((state == IDLE) && ic_req && dc_req && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int ML = 4;
  localparam int DW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ic_req, ic_grant, ic_done;
  logic [15:0] ic_addr, ic_rdata;
  logic        dc_req, dc_wr, dc_grant, dc_done;
  logic [15:0] dc_addr, dc_wdata, dc_rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  // Second instance with a one-cycle memory.
  logic        ic_req1, ic_grant1, ic_done1;
  logic [15:0] ic_addr1, ic_rdata1;
  logic        dc_req1, dc_wr1, dc_grant1, dc_done1;
  logic [15:0] dc_addr1, dc_wdata1, dc_rdata1;
  logic        mem_en1, mem_wr1;
  logic [15:0] mem_addr1, mem_wdata1, mem_rdata1;

`ifdef ARB_STATS_EN
  logic [15:0] icCnt, dcCnt, cfCnt, icCnt1, dcCnt1, cfCnt1;
`endif

  mem_arbiter #(.MEM_LAT(ML), .DWIN_MAX(DW)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_grant(ic_grant), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_grant(dc_grant), .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef ARB_STATS_EN
    .ic_grant_cnt(icCnt), .dc_grant_cnt(dcCnt), .conflict_cnt(cfCnt),
`endif
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LAT(1), .DWIN_MAX(DW)) dut1 (
    .clk(clk), .rst(rst),
    .ic_req(ic_req1), .ic_addr(ic_addr1), .ic_grant(ic_grant1), .ic_done(ic_done1), .ic_rdata(ic_rdata1),
    .dc_req(dc_req1), .dc_wr(dc_wr1), .dc_addr(dc_addr1), .dc_wdata(dc_wdata1),
    .dc_grant(dc_grant1), .dc_done(dc_done1), .dc_rdata(dc_rdata1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
`ifdef ARB_STATS_EN
    .ic_grant_cnt(icCnt1), .dc_grant_cnt(dcCnt1), .conflict_cnt(cfCnt1),
`endif
    .mem_rdata(mem_rdata1)
  );

  assign mem_rdata1 = (mem_addr1 == 16'h0040) ? 16'hA5C3 : 16'h0000;

  // Memory environment: unwritten words hold a fixed address-derived pattern.
  function automatic logic [15:0] initVal(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5};
  endfunction

  logic [15:0] memArr [0:65535];
  bit          memSet [0:65535];
  assign mem_rdata = memSet[mem_addr] ? memArr[mem_addr] : initVal(mem_addr);
  always @(posedge clk) begin
    if (mem_en && mem_wr) begin
      memArr[mem_addr] <= mem_wdata;
      memSet[mem_addr] <= 1'b1;
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic checkI(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model: one transaction record stamped with its decision cycle.
  logic [15:0] refMem [0:65535];
  bit          refSet [0:65535];
  bit          mActive, mOwnerD, mWr, addrZero, pD;
  logic [15:0] mAddr, mWdata, mData, expIc, expDc;
  int          mStart, mDwin, k, wrCyc;
  bit          eG, eD, prevIg, prevDg;
  int          actGrants[$];

  initial begin
    mActive = 0; mDwin = 0; expIc = 16'h0; expDc = 16'h0; addrZero = 1;
    prevIg = 0; prevDg = 0; wrCyc = 0; mOwnerD = 0; mWr = 0; mStart = 0;
    forever begin
      @(negedge clk);
      k  = mActive ? (cyc - mStart) : 0;
      eG = mActive && (k >= 1) && (k <= ML);
      eD = mActive && (k == ML + 1);
      if (eD && !mWr) begin
        if (mOwnerD) expDc = mData;
        else         expIc = mData;
      end
      check1("ic_grant", ic_grant, eG && !mOwnerD);
      check1("dc_grant", dc_grant, eG && mOwnerD);
      check1("ic_done", ic_done, eD && !mOwnerD);
      check1("dc_done", dc_done, eD && mOwnerD);
      check1("mem_en", mem_en, eG);
      check1("mem_wr", mem_wr, eG && mWr);
      check16("ic_rdata", ic_rdata, expIc);
      check16("dc_rdata", dc_rdata, expDc);
      if (eG) check16("mem_addr", mem_addr, mAddr);
      if (eG && mWr) check16("mem_wdata", mem_wdata, mWdata);
      if (addrZero) begin
        check16("mem_addr_rst", mem_addr, 16'h0);
        check16("mem_wdata_rst", mem_wdata, 16'h0);
      end
      if (mem_wr) wrCyc++;
      if (ic_grant && !prevIg) actGrants.push_back(0);
      if (dc_grant && !prevDg) actGrants.push_back(1);
      prevIg = ic_grant;
      prevDg = dc_grant;
      // Advance using the inputs the DUT samples at the coming edge.
      if (rst) begin
        mActive = 0; mDwin = 0; expIc = 16'h0; expDc = 16'h0; addrZero = 1;
      end else if ((!mActive || k >= ML + 2) && (ic_req || dc_req)) begin
        pD = dc_req && !(ic_req && mDwin == DW);
        if (pD && ic_req) mDwin = (mDwin < DW) ? mDwin + 1 : DW;
        else              mDwin = 0;
        mActive = 1; mOwnerD = pD; mStart = cyc; addrZero = 0;
        mWr    = pD && dc_wr;
        mAddr  = pD ? dc_addr : ic_addr;
        mWdata = dc_wdata;
        if (mWr) begin
          refMem[mAddr] = mWdata;
          refSet[mAddr] = 1'b1;
        end else begin
          mData = refSet[mAddr] ? refMem[mAddr] : initVal(mAddr);
        end
      end else if (mActive && k >= ML + 2) begin
        mActive = 0;
      end
    end
  end

  // Requester tasks: call at posedge+1; return at posedge+1 of the done cycle
  // with the request already dropped.
  task automatic doI(input logic [15:0] a, output int st, output int dn);
    dn = -1;
    st = cyc;
    ic_addr = a;
    ic_req = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (ic_done) begin
        dn = cyc;
        break;
      end
    end
    ic_req = 1'b0;
    check1("ic_done_seen", dn >= 0, 1'b1);
  endtask

  task automatic doD(input logic w, input logic [15:0] a, input logic [15:0] wd,
                     output int st, output int dn);
    dn = -1;
    st = cyc;
    dc_wr = w;
    dc_addr = a;
    dc_wdata = wd;
    dc_req = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (dc_done) begin
        dn = cyc;
        break;
      end
    end
    dc_req = 1'b0;
    check1("dc_done_seen", dn >= 0, 1'b1);
  endtask

  int s, d, sI, dI, sD, dD, nG, wrBefore;
  bit seen;
  int pat [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ic_req = 0; ic_addr = 0; dc_req = 0; dc_wr = 0; dc_addr = 0; dc_wdata = 0;
    ic_req1 = 0; ic_addr1 = 0; dc_req1 = 0; dc_wr1 = 0; dc_addr1 = 0; dc_wdata1 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check1("rst_ic_grant", ic_grant, 1'b0);
    check1("rst_dc_grant", dc_grant, 1'b0);
    check1("rst_mem_en", mem_en, 1'b0);
    check16("rst_ic_rdata", ic_rdata, 16'h0);
    check16("rst_dc_rdata", dc_rdata, 16'h0);

    // I read alone
    @(posedge clk); #1;
    wrBefore = wrCyc;
    doI(16'h0010, s, d);
    checkI("i_latency", d - s, ML + 1);
    check16("i_rdata", ic_rdata, 16'hBEEF);
    checkI("i_no_write", wrCyc - wrBefore, 0);

    // D write then read back
    @(posedge clk); #1;
    wrBefore = wrCyc;
    doD(1'b1, 16'h0200, 16'h1234, s, d);
    checkI("dw_latency", d - s, ML + 1);
    checkI("dw_wr_cycles", wrCyc - wrBefore, ML);
    check16("dw_rdata_kept", dc_rdata, 16'h0000);
    @(posedge clk); #1;
    doD(1'b0, 16'h0200, 16'h0, s, d);
    check16("dr_rdata", dc_rdata, 16'h1234);

    // Simultaneous requests: D first, I right after
    @(posedge clk); #1;
    fork
      doI(16'h0010, sI, dI);
      doD(1'b0, 16'h0200, 16'h0, sD, dD);
    join
    checkI("sim_d_done", dD - sD, ML + 1);
    checkI("sim_i_done", dI - sI, 2 * ML + 3);
    check16("sim_i_rdata", ic_rdata, 16'hBEEF);

    // Starvation guard over two windows
    @(posedge clk); #1;
    nG = actGrants.size();
    fork
      begin
        doI(16'h0011, sI, dI);
        doI(16'h0012, sI, dI);
      end
      begin
        for (int j = 0; j < 6; j++) doD(1'b0, 16'h0020 + 16'(j), 16'h0, sD, dD);
      end
    join
    for (int j = 0; j < 8; j++)
      checkI("starve_order", (actGrants.size() > nG + j) ? actGrants[nG + j] : -1, pat[j]);

    // Randomized traffic on overlapping addresses
    @(posedge clk); #1;
    fork
      begin
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          doI(16'($urandom_range(16, 23)), sI, dI);
        end
      end
      begin
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          doD(1'($urandom_range(0, 1)), 16'($urandom_range(16, 23)), 16'($urandom), sD, dD);
        end
      end
    join

    // One-cycle memory configuration
    @(posedge clk); #1;
    ic_addr1 = 16'h0040;
    ic_req1 = 1'b1;
    @(posedge clk); #1;
    check1("l1_grant_c1", ic_grant1, 1'b1);
    check1("l1_done_c1", ic_done1, 1'b0);
    @(posedge clk); #1;
    ic_req1 = 1'b0;
    check1("l1_grant_c2", ic_grant1, 1'b0);
    check1("l1_done_c2", ic_done1, 1'b1);
    check16("l1_rdata", ic_rdata1, 16'hA5C3);
    @(posedge clk); #1;
    check1("l1_done_c3", ic_done1, 1'b0);
    check1("l1_grant_c3", ic_grant1, 1'b0);

    // Reset in the middle of a D write
    @(posedge clk); #1;
    dc_wr = 1'b1; dc_addr = 16'h0300; dc_wdata = 16'hCAFE; dc_req = 1'b1;
    @(posedge clk); #1;
    check1("rb_grant_c1", dc_grant, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    dc_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check1("rb_dc_grant", dc_grant, 1'b0);
    check1("rb_mem_en", mem_en, 1'b0);
    check1("rb_mem_wr", mem_wr, 1'b0);
    check16("rb_mem_addr", mem_addr, 16'h0);
    check16("rb_mem_wdata", mem_wdata, 16'h0);
    check16("rb_dc_rdata", dc_rdata, 16'h0);
    check16("rb_ic_rdata", ic_rdata, 16'h0);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (dc_done) seen = 1;
    end
    check1("rb_no_done", seen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
